// File: rtl/hann_pkg.sv
// Shared defaults and elaboration-time helpers for the Hann window block.
// The coefficient function is evaluated only while building the ROM contents.
package hann_pkg;

   localparam int DEF_SAMPLE_WIDTH = 8;
   localparam int DEF_WINDOW_LEN   = 4096;
   localparam int DEF_COEF_WIDTH   = 16;

   localparam real PI = 3.14159265358979323846;

   function automatic int idx_width(input int len);
      return $clog2(len);
   endfunction

   // round((2^cw - 1) * 0.5 * (1 - cos(2*pi*n/(len-1)))), always non-negative
   function automatic int hann_coef(input int n, input int len, input int cw);
      real w;
      w = 0.5 * (1.0 - $cos(2.0 * PI * real'(n) / real'(len - 1)));
      return $rtoi(w * ((2.0 ** cw) - 1.0) + 0.5);
   endfunction

endpackage

// File: rtl/hann_coef_rom.sv
// Half-length Hann coefficient ROM with registered read.
// The upper half of the frame is served by mirroring the index onto the lower half.
module hann_coef_rom
   import hann_pkg::*;
#(
   parameter int WINDOW_LEN = DEF_WINDOW_LEN,
   parameter int COEF_WIDTH = DEF_COEF_WIDTH,
   localparam int IW = idx_width(WINDOW_LEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IW-1:0]         n,
   output logic [COEF_WIDTH-1:0] coef
);

   localparam int HALF = WINDOW_LEN / 2;

   logic [IW-2:0]         addr;
   logic [COEF_WIDTH-1:0] rom [HALF];

   generate
      for (genvar gi = 0; gi < HALF; gi++) begin : g_rom
         assign rom[gi] = COEF_WIDTH'(hann_coef(gi, WINDOW_LEN, COEF_WIDTH));
      end
   endgenerate

   // For n >= WINDOW_LEN/2, WINDOW_LEN-1-n is just the inverted low bits of n.
   assign addr = n[IW-1] ? ~n[IW-2:0] : n[IW-2:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         coef <= '0;
      end else begin
         coef <= rom[addr];
      end
   end

endmodule

// File: rtl/hann_window.sv
// Streaming Hann window multiplier: one signed sample per clock in, windowed
// sample out two cycles later at the same width.
module hann_window
   import hann_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int WINDOW_LEN   = DEF_WINDOW_LEN,
   parameter int COEF_WIDTH   = DEF_COEF_WIDTH
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
   output logic signed [SAMPLE_WIDTH-1:0] out_sample
);

   localparam int IW = idx_width(WINDOW_LEN);
   localparam int PW = SAMPLE_WIDTH + COEF_WIDTH + 1;

   logic [IW-1:0]                  n_reg;
   logic signed [SAMPLE_WIDTH-1:0] sample_reg;
   logic [COEF_WIDTH-1:0]          coef;
   logic signed [PW-1:0]           prod;

   // Power-of-two frame length lets the counter wrap naturally.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         n_reg      <= '0;
         sample_reg <= '0;
         out_sample <= '0;
      end else begin
         n_reg      <= n_reg + IW'(1);
         sample_reg <= in_sample;
         out_sample <= SAMPLE_WIDTH'(prod >>> COEF_WIDTH);
      end
   end

   hann_coef_rom #(
      .WINDOW_LEN (WINDOW_LEN),
      .COEF_WIDTH (COEF_WIDTH)
   ) u_rom (
      .clk   (clk_in),
      .rst_n (rst_in),
      .n     (n_reg),
      .coef  (coef)
   );

   // Coefficient is zero-extended so the multiply stays signed; |coef| < 2^COEF_WIDTH
   // keeps the floored result within the input range, so no saturation.
   always_comb begin
      prod = PW'(sample_reg) * PW'($signed({1'b0, coef}));
   end

endmodule

// File: tb/tb_hann_window.sv
// Self-checking bench for hann_window: a latency-aware behavioural model checks
// every output, plus table-driven point vectors and frame-level sequences.
module tb_hann_window;

   localparam int N = 4096;

   logic              clk_in;
   logic              rst_in;
   logic signed [7:0] in_sample;
   logic signed [7:0] out_sample;

   int n_checks = 0;
   int n_fail   = 0;

   int  coef_tab [N];
   int  n_model;
   bit  prev_ok;
   int  prev_val;
   int  exp_out;
   logic signed [31:0] outs [N + 16];

   typedef struct {
      int pos;
      int x;
      int expv;
   } vec_t;
   vec_t vecs [9];

   hann_window dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .in_sample  (in_sample),
      .out_sample (out_sample)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   function automatic int win(input int x, input int n);
      longint p;
      p = longint'(x) * longint'(coef_tab[n]);
      return int'($floor(real'(p) / 65536.0));
   endfunction

   task automatic check(input string name, input logic signed [31:0] act, input int expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // One clock: drive inputs, step past the edge, advance the model and compare.
   // Output after an edge is the windowed sample accepted on the previous edge,
   // or zero if either of those two edges was a reset edge.
   task automatic cycle(input int x, input bit rst);
      logic signed [7:0] xs;
      xs        = 8'(x);
      in_sample = xs;
      rst_in    = !rst;
      @(posedge clk_in);
      #1;
      if (rst) begin
         exp_out = 0;
         prev_ok = 1'b0;
         n_model = 0;
      end else begin
         exp_out  = prev_ok ? prev_val : 0;
         prev_ok  = 1'b1;
         prev_val = win(int'(xs), n_model);
         n_model  = (n_model + 1) % N;
      end
      check("model", out_sample, exp_out);
   endtask

   task automatic run_point(input int id, input int pos, input int x, input int expv);
      cycle(0, 1'b1);
      cycle(0, 1'b1);
      for (int k = 0; k <= pos + 2; k++) begin
         cycle((k == pos) ? x : 0, 1'b0);
         if (k == pos + 1)
            check($sformatf("vec%0d_out", id), out_sample, expv);
         else if (k == pos || k == pos + 2)
            check($sformatf("vec%0d_nbr", id), out_sample, 0);
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++)
         coef_tab[k] = $rtoi(65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N - 1))) + 0.5);

      vecs[0] = '{pos: 2048, x: -128, expv: -128};
      vecs[1] = '{pos: 2048, x: 127,  expv: 126};
      vecs[2] = '{pos: 1024, x: 100,  expv: 50};
      vecs[3] = '{pos: 2047, x: 100,  expv: 99};
      vecs[4] = '{pos: 2048, x: 100,  expv: 99};
      vecs[5] = '{pos: 0,    x: 100,  expv: 0};
      vecs[6] = '{pos: 4095, x: 100,  expv: 0};
      vecs[7] = '{pos: 1024, x: -1,   expv: -1};
      vecs[8] = '{pos: 2000, x: 0,    expv: 0};

      n_model   = 0;
      prev_ok   = 1'b0;
      prev_val  = 0;
      rst_in    = 1'b0;
      in_sample = '0;

      // Reset held for two cycles with a nonzero input, then a constant-100 frame.
      cycle(100, 1'b1);
      check("reset_out0", out_sample, 0);
      cycle(100, 1'b1);
      check("reset_out1", out_sample, 0);
      for (int e = 1; e <= N + 1; e++) begin
         cycle(100, 1'b0);
         outs[e] = out_sample;
      end
      check("flush_out", outs[1], 0);
      check("c100_n0", outs[2], 0);
      check("c100_n1024", outs[1026], 50);
      check("c100_n2047", outs[2049], 99);
      check("c100_n2048", outs[2050], 99);
      check("c100_n4095", outs[N + 1], 0);

      // Point vectors: impulse at pos amid zeros, exact 2-cycle latency.
      foreach (vecs[i])
         run_point(i, vecs[i].pos, vecs[i].x, vecs[i].expv);

      // Zero input yields zero at every index.
      cycle(0, 1'b1);
      for (int e = 1; e <= N + 2; e++) begin
         cycle(0, 1'b0);
         check("zero_in", out_sample, 0);
      end

      // Wrap: index N returns to 0 without a gap.
      cycle(64, 1'b1);
      for (int e = 1; e <= N + 10; e++) begin
         cycle(64, 1'b0);
         outs[e] = out_sample;
      end
      check("wrap_n4095", outs[N + 1], 0);
      check("wrap_n4096", outs[N + 2], 0);
      check("wrap_n4097", outs[N + 3], win(64, 1));

      // Reset one cycle at n=1500; numbering restarts from 0.
      cycle(100, 1'b1);
      for (int e = 1; e <= 1500; e++)
         cycle(100, 1'b0);
      cycle(100, 1'b1);
      check("midrst_out", out_sample, 0);
      for (int e = 1; e <= 1030; e++) begin
         cycle(100, 1'b0);
         outs[e] = out_sample;
      end
      check("midrst_flush", outs[1], 0);
      check("midrst_n0", outs[2], 0);
      check("midrst_n1024", outs[1026], 50);

      // Ramp over a full frame.
      cycle(0, 1'b1);
      for (int i = 0; i < N; i++)
         cycle((i << 4) % 256, 1'b0);
      cycle(0, 1'b0);
      cycle(0, 1'b0);

      // Random samples with occasional reset pulses.
      for (int i = 0; i < 3000; i++)
         cycle(int'($urandom_range(0, 255)), ($urandom_range(0, 299) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
